rv32i_mem_arbiter: RTL and testbench
====================================

Name: rv32i_mem_arbiter

Overview:
Shares one single-port unified memory between the pipeline's instruction-fetch port and its data port. The block sits between the RV32i top and the memory.
- It arbitrates between the two requests, latches the granted request, and drives a req/ack handshake to memory.
- It returns registered read data with a one-cycle valid pulse to the requester. The core's existing stall logic (fetch valid, mem valid) therefore works unchanged.
- It bounds memory latency with a timeout counter.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width (BLE width = DATA_W/8)
ACK_TIMEOUT, 255, max cycles waiting for mem_ack_i before abort; 0 disables timeout

Ports:
clk_i  in  1  clock
resetn_i  in  1  asynchronous active-low reset
imem_re_i  in  1  fetch request (held until imem_valid_o)
imem_add_i  in  ADDR_W  fetch address
imem_data_o  out  DATA_W  fetch data, registered
imem_valid_o  out  1  one-cycle completion pulse for fetch
dmem_re_i  in  1  data read request (held until dmem_valid_o)
dmem_we_i  in  1  data write request (held until dmem_valid_o)
dmem_add_i  in  ADDR_W  data address
dmem_di_i  in  DATA_W  write data
dmem_ble_i  in  DATA_W/8  byte lane enables
dmem_do_o  out  DATA_W  read data, registered
dmem_valid_o  out  1  one-cycle completion pulse for data access
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  write strobe
mem_add_o  out  ADDR_W  memory address
mem_di_o  out  DATA_W  memory write data
mem_ble_o  out  DATA_W/8  memory byte enables
mem_do_i  in  DATA_W  memory read data, valid when mem_ack_i=1
mem_ack_i  in  1  memory completion
bus_err_o  out  1  sticky timeout error

Behaviour:
- Reset (async, resetn_i=0): state=IDLE. All outputs are 0, including data registers, bus_err_o and the timeout counter.
- FSM states are IDLE, I_ACC, D_ACC, I_RESP, D_RESP.
- Arbitration:
  - Evaluated in IDLE, I_RESP and D_RESP only.
  - A data request is pending when dmem_re_i|dmem_we_i.
  - Fixed priority: data > fetch, because data belongs to the older instruction.
  - In I_RESP only the data port is eligible; in D_RESP only the fetch port is eligible. The responding port's request is still asserted in its valid cycle and must not be re-issued.
- Grant: the cycle after the grant decision, the state is I_ACC or D_ACC and the mem_* outputs are valid. Address, wdata, BLE and we are latched at grant and held stable for the whole access, whatever the inputs do afterwards.
  - mem_we_o=dmem_we_i for data grants, 0 for fetch grants.
  - mem_ble_o is all-ones for fetch.
  - If dmem_we_i and dmem_re_i are both set, treat the access as a write.
- Access: mem_req_o=1 in I_ACC/D_ACC until the cycle mem_ack_i=1. mem_req_o is registered and drops the cycle after ack. mem_ack_i outside ACC states is ignored.
- Completion on ack:
  - Read: mem_do_i is captured into imem_data_o or dmem_do_o.
  - Write: dmem_do_o is held unchanged.
  - Next state is I_RESP/D_RESP, where the matching valid is high for exactly one cycle.
  - Minimum latency, request to valid: 3 cycles with ack in the first access cycle (grant, access, resp).
- Back-to-back: a new grant can be made in a RESP state, so the next access starts the cycle after RESP.
- Timeout:
  - The counter clears at grant and increments each ACC cycle without ack.
  - When it reaches ACK_TIMEOUT: drop mem_req_o, set bus_err_o=1 (sticky until reset), load 0 as read data, and go to RESP with valid asserted so the core does not deadlock.
  - Ack and timeout in the same cycle: ack wins, no error.
- Data outputs hold their last value outside valid cycles. Valid never asserts in any state other than RESP.
- Reset mid-access: the access is abandoned immediately (mem_req_o=0) with no response.

Optional Feature:
RV32I_MEM_ARB_RR_EN.
- Defined: round-robin replaces fixed priority. A last_grant flop (reset value = fetch) gives priority to the port not granted last when both are pending in IDLE. RESP-state eligibility rules are unchanged.
- Undefined: fixed data>fetch priority, and no last_grant flop is present.

Test Plan:
1. Fetch only, imem_add_i=0x100, memory acks on 1st access cycle with 0x00000013 -> mem_add_o=0x100, mem_we_o=0, mem_ble_o=0xF; imem_data_o=0x00000013; imem_valid_o high exactly 1 cycle, 3 cycles after request.
2. Fetch and data read both pending in IDLE, dmem_add_i=0x2000 -> data granted first. Fetch starts in D_RESP, so the second mem_req_o rises the cycle after dmem_valid_o. No duplicate data access. With RR_EN and last_grant=data, fetch goes first.
3. Write dmem_add_i=0x2004, dmem_di_i=0xDEADBEEF, ble=0x3; ack delayed 4 cycles; inputs changed during wait -> mem_* hold 0x2004/0xDEADBEEF/0x3 until ack; dmem_do_o unchanged; one dmem_valid_o pulse.
4. ACK_TIMEOUT=8, memory never acks a fetch -> mem_req_o drops after 8 cycles, bus_err_o=1 and stays 1, imem_data_o=0, imem_valid_o pulses once; the next fetch proceeds normally.
5. Ack arrives in the exact cycle the counter hits ACK_TIMEOUT -> data captured, bus_err_o stays 0.
6. resetn_i pulsed low during D_ACC -> all outputs 0 asynchronously, state IDLE, no valid pulse; re-issued request completes normally.

Source files
------------

// File: rtl/rv32i_mem_arbiter.sv
// Arbiter that shares one single-port unified memory between instruction fetch and data access.
// Define RV32I_MEM_ARB_RR_EN to replace fixed data>fetch priority with round-robin in IDLE.
module rv32i_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                clk_i,
    input  logic                resetn_i,
    input  logic                imem_re_i,
    input  logic [ADDR_W-1:0]   imem_add_i,
    output logic [DATA_W-1:0]   imem_data_o,
    output logic                imem_valid_o,
    input  logic                dmem_re_i,
    input  logic                dmem_we_i,
    input  logic [ADDR_W-1:0]   dmem_add_i,
    input  logic [DATA_W-1:0]   dmem_di_i,
    input  logic [DATA_W/8-1:0] dmem_ble_i,
    output logic [DATA_W-1:0]   dmem_do_o,
    output logic                dmem_valid_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_add_o,
    output logic [DATA_W-1:0]   mem_di_o,
    output logic [DATA_W/8-1:0] mem_ble_o,
    input  logic [DATA_W-1:0]   mem_do_i,
    input  logic                mem_ack_i,
    output logic                bus_err_o
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam bit TO_EN = (ACK_TIMEOUT != 0);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] I_ACC  = 3'd1;
    localparam logic [2:0] D_ACC  = 3'd2;
    localparam logic [2:0] I_RESP = 3'd3;
    localparam logic [2:0] D_RESP = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             d_pend;
    logic             d_elig;
    logic             i_elig;
    logic             grant_d;
    logic             grant_i;
    logic             timeout_hit;

`ifdef RV32I_MEM_ARB_RR_EN
    logic last_grant;  // 1 = data granted last, 0 = fetch

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            last_grant <= 1'b0;
        end else if (grant_d) begin
            last_grant <= 1'b1;
        end else if (grant_i) begin
            last_grant <= 1'b0;
        end
    end
`endif

    // The port that is responding this cycle still holds its request, so it is excluded.
    always_comb begin
        d_pend  = dmem_re_i | dmem_we_i;
        d_elig  = (state == IDLE) || (state == I_RESP);
        i_elig  = (state == IDLE) || (state == D_RESP);
`ifdef RV32I_MEM_ARB_RR_EN
        grant_d = d_elig && d_pend && !((state == IDLE) && imem_re_i && last_grant);
`else
        grant_d = d_elig && d_pend;
`endif
        grant_i = i_elig && imem_re_i && !grant_d;
        timeout_hit = TO_EN && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state        <= IDLE;
            cnt          <= '0;
            imem_data_o  <= '0;
            imem_valid_o <= 1'b0;
            dmem_do_o    <= '0;
            dmem_valid_o <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_add_o    <= '0;
            mem_di_o     <= '0;
            mem_ble_o    <= '0;
            bus_err_o    <= 1'b0;
        end else begin
            imem_valid_o <= 1'b0;
            dmem_valid_o <= 1'b0;
            case (state)
                IDLE, I_RESP, D_RESP: begin
                    if (grant_d) begin
                        state     <= D_ACC;
                        mem_req_o <= 1'b1;
                        mem_we_o  <= dmem_we_i;
                        mem_add_o <= dmem_add_i;
                        mem_di_o  <= dmem_di_i;
                        mem_ble_o <= dmem_ble_i;
                        cnt       <= '0;
                    end else if (grant_i) begin
                        state     <= I_ACC;
                        mem_req_o <= 1'b1;
                        mem_we_o  <= 1'b0;
                        mem_add_o <= imem_add_i;
                        mem_di_o  <= '0;
                        mem_ble_o <= '1;
                        cnt       <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                I_ACC, D_ACC: begin
                    // Ack takes precedence over a timeout landing in the same cycle.
                    if (mem_ack_i || timeout_hit) begin
                        mem_req_o <= 1'b0;
                        if (!mem_ack_i) begin
                            bus_err_o <= 1'b1;
                        end
                        if (state == I_ACC) begin
                            imem_data_o  <= mem_ack_i ? mem_do_i : '0;
                            imem_valid_o <= 1'b1;
                            state        <= I_RESP;
                        end else begin
                            if (!mem_we_o) begin
                                dmem_do_o <= mem_ack_i ? mem_do_i : '0;
                            end
                            dmem_valid_o <= 1'b1;
                            state        <= D_RESP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Scoreboard bench for rv32i_mem_arbiter: expected read data is queued at issue and
// checked by a monitor on each valid pulse; directed checks cover the memory-side timing.
module tb_rv32i_mem_arbiter;

    logic        clk;
    logic        resetn;
    logic        imem_re_i;
    logic [31:0] imem_add_i;
    logic [31:0] imem_data_o;
    logic        imem_valid_o;
    logic        dmem_re_i;
    logic        dmem_we_i;
    logic [31:0] dmem_add_i;
    logic [31:0] dmem_di_i;
    logic [3:0]  dmem_ble_i;
    logic [31:0] dmem_do_o;
    logic        dmem_valid_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_add_o;
    logic [31:0] mem_di_o;
    logic [3:0]  mem_ble_o;
    logic [31:0] mem_do_i;
    logic        mem_ack_i;
    logic        bus_err_o;

    rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ACK_TIMEOUT(8)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .imem_re_i(imem_re_i), .imem_add_i(imem_add_i), .imem_data_o(imem_data_o),
        .imem_valid_o(imem_valid_o),
        .dmem_re_i(dmem_re_i), .dmem_we_i(dmem_we_i), .dmem_add_i(dmem_add_i),
        .dmem_di_i(dmem_di_i), .dmem_ble_i(dmem_ble_i), .dmem_do_o(dmem_do_o),
        .dmem_valid_o(dmem_valid_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_add_o(mem_add_o),
        .mem_di_o(mem_di_o), .mem_ble_o(mem_ble_o), .mem_do_i(mem_do_i),
        .mem_ack_i(mem_ack_i), .bus_err_o(bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];

    int ack_delay = 0;
    bit ack_never = 1'b0;
    int wcnt = 0;

    int          obs_nreq;
    int          obs_rises;
    int          obs_rise_k[2];
    logic [31:0] obs_add[2];
    logic [31:0] obs_di0;
    logic [3:0]  obs_ble0;
    logic        obs_we0;
    bit          obs_hold_ok;
    int          obs_ivk;
    int          obs_dvk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000_0013;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Memory model: acks after ack_delay un-acked access cycles.
    initial begin
        mem_ack_i = 1'b0;
        mem_do_i  = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o && !mem_ack_i) begin
                if (!ack_never && wcnt == ack_delay) begin
                    mem_ack_i = 1'b1;
                    mem_do_i  = mem_rd(mem_add_o);
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                mem_ack_i = 1'b0;
                if (!mem_req_o) wcnt = 0;
            end
        end
    end

    // Core model: drops a request right after its valid cycle.
    initial begin
        logic di, dd;
        forever begin
            @(negedge clk);
            di = imem_valid_o;
            dd = dmem_valid_o;
            @(posedge clk);
            #1;
            if (di) imem_re_i = 1'b0;
            if (dd) begin
                dmem_re_i = 1'b0;
                dmem_we_i = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (imem_valid_o) begin
                if (exp_i.size() == 0) chk("imem_valid_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_i.pop_front();
                    chk("imem_data", imem_data_o, e);
                end
            end
            if (dmem_valid_o) begin
                if (exp_d.size() == 0) chk("dmem_valid_unexpected", 32'd1, 32'd0);
                else begin
                    e = exp_d.pop_front();
                    chk("dmem_do", dmem_do_o, e);
                end
            end
        end
    end

    task automatic observe(input int n);
        logic        prev;
        logic [31:0] ca, cd;
        logic [3:0]  cb;
        logic        cw;
        prev = 1'b0;
        obs_nreq = 0; obs_rises = 0; obs_hold_ok = 1'b1; obs_ivk = 0; obs_dvk = 0;
        obs_rise_k[0] = 0; obs_rise_k[1] = 0; obs_add[0] = '0; obs_add[1] = '0;
        ca = '0; cd = '0; cb = '0; cw = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (mem_req_o) begin
                if (!prev) begin
                    if (obs_rises < 2) begin
                        obs_add[obs_rises]    = mem_add_o;
                        obs_rise_k[obs_rises] = k;
                    end
                    if (obs_rises == 0) begin
                        obs_di0 = mem_di_o; obs_ble0 = mem_ble_o; obs_we0 = mem_we_o;
                    end
                    ca = mem_add_o; cd = mem_di_o; cb = mem_ble_o; cw = mem_we_o;
                    obs_rises++;
                end else if (mem_add_o !== ca || mem_di_o !== cd || mem_ble_o !== cb || mem_we_o !== cw) begin
                    obs_hold_ok = 1'b0;
                end
                obs_nreq++;
            end
            prev = mem_req_o;
            if (imem_valid_o && obs_ivk == 0) obs_ivk = k;
            if (dmem_valid_o && obs_dvk == 0) obs_dvk = k;
        end
    endtask

    task automatic wait_done();
        int budget;
        budget = 100;
        while ((imem_re_i || dmem_re_i || dmem_we_i) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            chk("request_never_completed", 32'd1, 32'd0);
            imem_re_i = 1'b0; dmem_re_i = 1'b0; dmem_we_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        imem_re_i = 1'b0; imem_add_i = '0;
        dmem_re_i = 1'b0; dmem_we_i = 1'b0; dmem_add_i = '0; dmem_di_i = '0; dmem_ble_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mem_add", mem_add_o, 32'd0);
        chk("rst_imem_data", imem_data_o, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err_o}, 32'd0);
        resetn = 1'b1;

        // 1: single fetch, ack in first access cycle
        @(posedge clk); #1;
        imem_add_i = 32'h100; imem_re_i = 1'b1; exp_i.push_back(32'h0000_0013);
        observe(6);
        chk("t1_rises", obs_rises, 1);
        chk("t1_add", obs_add[0], 32'h100);
        chk("t1_we", {31'd0, obs_we0}, 32'd0);
        chk("t1_ble", {28'd0, obs_ble0}, 32'hF);
        chk("t1_valid_latency", obs_ivk, 3);
        wait_done();

        // 2: fetch and data read pending together
        @(posedge clk); #1;
        imem_add_i = 32'h104; imem_re_i = 1'b1;
        dmem_add_i = 32'h2000; dmem_re_i = 1'b1; dmem_ble_i = 4'hF;
        exp_d.push_back(32'hC0DE_2000); exp_i.push_back(32'hC0DE_0104);
        observe(9);
        chk("t2_rises", obs_rises, 2);
        chk("t2_first_add", obs_add[0], 32'h2000);
        chk("t2_second_add", obs_add[1], 32'h104);
        chk("t2_dvalid_k", obs_dvk, 3);
        chk("t2_second_req_k", obs_rise_k[1], 4);
        chk("t2_ivalid_k", obs_ivk, 5);
        wait_done();

        // 3: delayed write with inputs changing mid-access
        ack_delay = 4;
        @(posedge clk); #1;
        dmem_add_i = 32'h2004; dmem_di_i = 32'hDEAD_BEEF; dmem_ble_i = 4'h3; dmem_we_i = 1'b1;
        exp_d.push_back(32'hC0DE_2000);
        fork
            observe(12);
            begin
                repeat (3) @(posedge clk);
                #1;
                dmem_add_i = 32'hFFFF_0000; dmem_di_i = 32'h1234_5678; dmem_ble_i = 4'hC;
            end
        join
        chk("t3_rises", obs_rises, 1);
        chk("t3_req_cycles", obs_nreq, 5);
        chk("t3_hold", {31'd0, obs_hold_ok}, 32'd1);
        chk("t3_add", obs_add[0], 32'h2004);
        chk("t3_di", obs_di0, 32'hDEAD_BEEF);
        chk("t3_ble", {28'd0, obs_ble0}, 32'h3);
        chk("t3_we", {31'd0, obs_we0}, 32'd1);
        chk("t3_dvalid_k", obs_dvk, 7);
        wait_done();

        // 4: fetch never acked -> timeout
        ack_delay = 0; ack_never = 1'b1;
        @(posedge clk); #1;
        imem_add_i = 32'h300; imem_re_i = 1'b1; exp_i.push_back(32'h0);
        observe(14);
        chk("t4_req_cycles", obs_nreq, 8);
        chk("t4_ivalid_k", obs_ivk, 10);
        chk("t4_bus_err", {31'd0, bus_err_o}, 32'd1);
        wait_done();
        ack_never = 1'b0;
        @(posedge clk); #1;
        imem_add_i = 32'h104; imem_re_i = 1'b1; exp_i.push_back(32'hC0DE_0104);
        observe(6);
        chk("t4_next_ivalid_k", obs_ivk, 3);
        chk("t4_bus_err_sticky", {31'd0, bus_err_o}, 32'd1);
        wait_done();

        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("t4_rst_bus_err", {31'd0, bus_err_o}, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // 5: ack lands on the final allowed cycle
        ack_delay = 7;
        @(posedge clk); #1;
        dmem_add_i = 32'h2008; dmem_re_i = 1'b1; dmem_ble_i = 4'hF;
        exp_d.push_back(32'hC0DE_2008);
        observe(14);
        chk("t5_req_cycles", obs_nreq, 8);
        chk("t5_dvalid_k", obs_dvk, 10);
        chk("t5_bus_err", {31'd0, bus_err_o}, 32'd0);
        wait_done();

        // 6: reset during D_ACC
        ack_delay = 0; ack_never = 1'b1;
        @(posedge clk); #1;
        dmem_add_i = 32'h200C; dmem_re_i = 1'b1;
        observe(3);
        chk("t6_in_access", {31'd0, mem_req_o}, 32'd1);
        #2;
        resetn = 1'b0; dmem_re_i = 1'b0;
        #1;
        chk("t6_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("t6_mem_add", mem_add_o, 32'd0);
        chk("t6_dmem_do", dmem_do_o, 32'd0);
        chk("t6_imem_data", imem_data_o, 32'd0);
        chk("t6_dvalid", {31'd0, dmem_valid_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1; ack_never = 1'b0;
        observe(5);
        chk("t6_no_access", obs_rises, 0);
        chk("t6_no_valid", obs_dvk, 0);
        @(posedge clk); #1;
        dmem_add_i = 32'h200C; dmem_re_i = 1'b1; exp_d.push_back(32'hC0DE_200C);
        observe(6);
        chk("t6_reissue_dvalid_k", obs_dvk, 3);
        wait_done();

        repeat (3) @(negedge clk);
        chk("exp_i_drained", exp_i.size(), 0);
        chk("exp_d_drained", exp_d.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
